// File: rtl/ecpri_pkg.sv
// Shared constants, FSM states and error codes for the eCPRI RMA receive path.
package ecpri_pkg;
  localparam logic [3:0] ECPRI_REV   = 4'h1;
  localparam logic [7:0] MSG_RMA     = 8'h04;
  localparam int         RMA_HDR_LEN = 12;

  typedef enum logic [2:0] {
    S_IDLE, S_SKIP, S_ECPRI_HDR, S_RMA_HDR, S_WR_DATA, S_RESP, S_DRAIN
  } state_e;

  localparam logic [2:0] ERR_NONE          = 3'd0;
  localparam logic [2:0] ERR_BAD_HDR       = 3'd1;
  localparam logic [2:0] ERR_BAD_TYPE      = 3'd2;
  localparam logic [2:0] ERR_BAD_RMA_OP    = 3'd3;
  localparam logic [2:0] ERR_BAD_LEN       = 3'd4;
  localparam logic [2:0] ERR_BAD_ADDR      = 3'd5;
  localparam logic [2:0] ERR_SIZE_MISMATCH = 3'd6;
  localparam logic [2:0] ERR_TRUNCATED     = 3'd7;
endpackage

// File: rtl/ecpri_sat_cnt.sv
// Saturating event counter; sticks at all-ones.
module ecpri_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)                  cnt_q <= '0;
    else if (inc_i && cnt_q != '1) cnt_q <= cnt_q + W'(1);
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/ecpri_rma_rx.sv
// eCPRI Remote Memory Access receive engine: header skip, RMA decode,
// write-data to local memory and one response descriptor per good request.
module ecpri_rma_rx
  import ecpri_pkg::*;
#(
  parameter int HDR_SKIP = 42,
  parameter int MEM_AW   = 16,
  parameter int MAX_LEN  = 256,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [7:0]        s_data_i,
  input  logic              s_valid_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  output logic              mem_we_o,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic              resp_is_write_o,
  output logic [7:0]        resp_rma_id_o,
  output logic [15:0]       resp_elem_id_o,
  output logic [MEM_AW-1:0] resp_addr_o,
  output logic [15:0]       resp_len_o,
  output logic              err_pulse_o,
  output logic [2:0]        err_code_o,
  output logic [CNT_W-1:0]  pkt_cnt_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);
  localparam logic [15:0] SKIP16   = 16'(HDR_SKIP);
  localparam logic [32:0] ADDR_LIM = 33'(1) << MEM_AW;

  state_e            state_q;
  logic [15:0]       idx_q, wcnt_q, psize_q, elem_q, len_q;
  logic [47:0]       addr_q;
  logic [7:0]        id_q, mem_data_q;
  logic              type_wr_q, pend_q, mem_we_q, err_pulse_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [2:0]        err_code_q, err_d;

  logic        acc, hdr_ph, in_hdr;
  logic [15:0] off, len_full;
  logic [32:0] end_addr;

  assign s_ready_o = (state_q != S_RESP);
  assign acc       = s_valid_i && s_ready_o;
  assign hdr_ph    = state_q inside {S_IDLE, S_SKIP, S_ECPRI_HDR, S_RMA_HDR};
  assign in_hdr    = (idx_q >= SKIP16);
  assign off       = idx_q - SKIP16;
  // On the final RMA header byte the length is still half in flight.
  assign len_full  = {len_q[7:0], s_data_i};
  assign end_addr  = 33'(addr_q[MEM_AW-1:0]) + 33'(len_full);

  always_comb begin
    err_d = ERR_NONE;
    if (acc && hdr_ph && in_hdr) begin
      case (off)
        16'd0:  if (s_data_i[7:4] != ECPRI_REV || s_data_i[0]) err_d = ERR_BAD_HDR;
        16'd1:  if (s_data_i != MSG_RMA) err_d = ERR_BAD_TYPE;
        16'd5:  if (s_data_i[7:5] != 3'd0 || s_data_i[3:0] != 4'd0) err_d = ERR_BAD_RMA_OP;
        16'd15: begin
          if (len_full == 16'd0 || len_full > 16'(MAX_LEN))
            err_d = ERR_BAD_LEN;
          else if (addr_q[47:MEM_AW] != '0 || end_addr > ADDR_LIM)
            err_d = ERR_BAD_ADDR;
          else if (type_wr_q && ({1'b0, psize_q} != 17'(RMA_HDR_LEN) + {1'b0, len_full}))
            err_d = ERR_SIZE_MISMATCH;
        end
        default: ;
      endcase
    end
    // A read may end on its last header byte; anything else ending early is truncated.
    if (err_d == ERR_NONE && acc && s_last_i) begin
      if (hdr_ph && !(in_hdr && off == 16'd15 && !type_wr_q)) err_d = ERR_TRUNCATED;
      if (state_q == S_WR_DATA && (wcnt_q + 16'd1) < len_q)   err_d = ERR_TRUNCATED;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wcnt_q      <= '0;
      pend_q      <= 1'b0;
      psize_q     <= '0;
      id_q        <= '0;
      type_wr_q   <= 1'b0;
      elem_q      <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      mem_we_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      // The byte that truncates a write is still written.
      if (acc && state_q == S_WR_DATA) begin
        mem_we_q   <= 1'b1;
        mem_addr_q <= addr_q[MEM_AW-1:0] + MEM_AW'(wcnt_q);
        mem_data_q <= s_data_i;
        wcnt_q     <= wcnt_q + 16'd1;
      end
      if (acc) idx_q <= s_last_i ? 16'd0 : idx_q + 16'd1;

      if (err_d != ERR_NONE) begin
        err_pulse_q <= 1'b1;
        err_code_q  <= err_d;
        pend_q      <= 1'b0;
        state_q     <= s_last_i ? S_IDLE : S_DRAIN;
      end else if (state_q == S_RESP) begin
        if (resp_ready_i) state_q <= S_IDLE;
      end else if (acc) begin
        case (state_q)
          S_WR_DATA: if (wcnt_q + 16'd1 == len_q) begin
            state_q <= s_last_i ? S_RESP : S_DRAIN;
            pend_q  <= !s_last_i;
          end
          S_DRAIN: if (s_last_i) begin
            state_q <= pend_q ? S_RESP : S_IDLE;
            pend_q  <= 1'b0;
          end
          default: begin
            if (!in_hdr) begin
              state_q <= (idx_q + 16'd1 >= SKIP16) ? S_ECPRI_HDR : S_SKIP;
            end else begin
              if (off == 16'd2 || off == 16'd3)  psize_q   <= {psize_q[7:0], s_data_i};
              if (off == 16'd4)                  id_q      <= s_data_i;
              if (off == 16'd5)                  type_wr_q <= s_data_i[4];
              if (off == 16'd6 || off == 16'd7)  elem_q    <= {elem_q[7:0], s_data_i};
              if (off >= 16'd8 && off <= 16'd13) addr_q    <= {addr_q[39:0], s_data_i};
              if (off >= 16'd14)                 len_q     <= {len_q[7:0], s_data_i};
              if (off == 16'd15) begin
                wcnt_q <= '0;
                if (type_wr_q)     state_q <= S_WR_DATA;
                else if (s_last_i) state_q <= S_RESP;
                else begin
                  state_q <= S_DRAIN;
                  pend_q  <= 1'b1;
                end
              end else begin
                state_q <= (off < 16'd3) ? S_ECPRI_HDR : S_RMA_HDR;
              end
            end
          end
        endcase
      end
    end
  end

  assign mem_we_o        = mem_we_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_data_o      = mem_data_q;
  assign resp_valid_o    = (state_q == S_RESP);
  assign resp_is_write_o = type_wr_q;
  assign resp_rma_id_o   = id_q;
  assign resp_elem_id_o  = elem_q;
  assign resp_addr_o     = addr_q[MEM_AW-1:0];
  assign resp_len_o      = len_q;
  assign err_pulse_o     = err_pulse_q;
  assign err_code_o      = err_code_q;

  ecpri_sat_cnt #(.W(CNT_W)) u_pkt_cnt (
    .clk_i(clk_i), .reset_i(reset_i),
    .inc_i(state_q == S_RESP && resp_ready_i), .cnt_o(pkt_cnt_o)
  );
  ecpri_sat_cnt #(.W(CNT_W)) u_drop_cnt (
    .clk_i(clk_i), .reset_i(reset_i),
    .inc_i(err_d != ERR_NONE), .cnt_o(drop_cnt_o)
  );
endmodule

// File: tb/tb_ecpri_rma_rx.sv
// Directed bench for ecpri_rma_rx: vector table of whole frames plus
// hand-written stall, back-to-back and mid-frame reset sequences.
module tb_ecpri_rma_rx;
  localparam int CW = 3;

  logic          clk = 1'b0, reset = 1'b1;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [15:0]   mem_addr;
  logic [7:0]    mem_data;
  logic          mem_we, resp_valid, resp_ready = 1'b1, resp_is_write;
  logic [7:0]    resp_rma_id;
  logic [15:0]   resp_elem_id, resp_addr, resp_len;
  logic          err_pulse;
  logic [2:0]    err_code;
  logic [CW-1:0] pkt_cnt, drop_cnt;

  always #5 clk = ~clk;

  ecpri_rma_rx #(.HDR_SKIP(42), .MEM_AW(16), .MAX_LEN(256), .CNT_W(CW)) dut (
    .clk_i(clk), .reset_i(reset), .s_data_i(s_data), .s_valid_i(s_valid),
    .s_last_i(s_last), .s_ready_o(s_ready), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .mem_we_o(mem_we), .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready), .resp_is_write_o(resp_is_write),
    .resp_rma_id_o(resp_rma_id), .resp_elem_id_o(resp_elem_id),
    .resp_addr_o(resp_addr), .resp_len_o(resp_len), .err_pulse_o(err_pulse),
    .err_code_o(err_code), .pkt_cnt_o(pkt_cnt), .drop_cnt_o(drop_cnt)
  );

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  msg;
    logic [7:0]  typ;
    logic [7:0]  id;
    logic [15:0] elem;
    logic [47:0] addr;
    logic [15:0] len;
    int          ps_adj;
    int          ndata;
    logic [31:0] d4;
    logic [2:0]  exp_err;
    int          exp_wr;
    bit          exp_resp;
  } vec_t;

  int checks = 0, errors = 0;
  int exp_pkt = 0, exp_drop = 0;

  // Monitor state
  logic [15:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  int n_errp = 0, n_resp = 0, n_rvc = 0, n_unstable = 0;
  logic [2:0]  last_err = '0;
  logic        prev_rv = 1'b0;
  logic [55:0] prev_f = '0;
  logic [55:0] cur_f;

  always @(negedge clk) begin
    cur_f = {resp_is_write, resp_rma_id, resp_elem_id, resp_addr, resp_len[14:0]};
    if (mem_we) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_data);
    end
    if (err_pulse) begin
      n_errp++;
      last_err = err_code;
    end
    if (resp_valid) begin
      n_rvc++;
      if (!prev_rv) n_resp++;
      else if (cur_f != prev_f) n_unstable++;
    end
    prev_rv = resp_valid;
    prev_f  = cur_f;
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: run did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x >= (1 << CW) - 1) ? (1 << CW) - 1 : x + 1;
  endfunction

  function automatic logic [7:0] dbyte(input vec_t v, input int k);
    logic [31:0] d;
    d = v.d4;
    if (k < 4) return d[31-8*k -: 8];
    return 8'(k * 13 + 5);
  endfunction

  task automatic clear_stats();
    wq_addr.delete();
    wq_data.delete();
    n_errp = 0; n_resp = 0; n_rvc = 0; n_unstable = 0;
  endtask

  // Drive one byte from a negedge; returns on the negedge after acceptance.
  task automatic put_byte(input logic [7:0] b, input logic last);
    int t = 0;
    s_data = b; s_last = last; s_valid = 1'b1;
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL s_ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input vec_t v, input int stop_at);
    logic [7:0]  b[$];
    logic [15:0] ps;
    logic [47:0] a;
    int n;
    a  = v.addr;
    ps = 16'(12 + ((v.typ == 8'h10) ? int'(v.len) : 0) + v.ps_adj);
    for (int i = 0; i < 42; i++) b.push_back(8'(i + 8'h60));
    b.push_back(v.b0); b.push_back(v.msg); b.push_back(ps[15:8]); b.push_back(ps[7:0]);
    b.push_back(v.id); b.push_back(v.typ); b.push_back(v.elem[15:8]); b.push_back(v.elem[7:0]);
    for (int i = 5; i >= 0; i--) b.push_back(a[8*i +: 8]);
    b.push_back(v.len[15:8]); b.push_back(v.len[7:0]);
    for (int k = 0; k < v.ndata; k++) b.push_back(dbyte(v, k));
    n = (stop_at > 0) ? stop_at : b.size();
    for (int i = 0; i < n; i++) put_byte(b[i], (stop_at == 0) && (i == n - 1));
  endtask

  task automatic chk_writes(input string nm, input vec_t v, input int nexp);
    int bad = 0;
    logic [15:0] base;
    base = v.addr[15:0];
    chk({nm, ".nwr"}, wq_addr.size(), nexp);
    for (int k = 0; k < nexp && k < wq_addr.size(); k++)
      if (wq_addr[k] !== base + 16'(k) || wq_data[k] !== dbyte(v, k)) bad++;
    chk({nm, ".wdata_bad"}, bad, 0);
  endtask

  task automatic chk_resp(input string nm, input vec_t v);
    chk({nm, ".is_write"}, resp_is_write, v.typ == 8'h10);
    chk({nm, ".rma_id"}, resp_rma_id, v.id);
    chk({nm, ".elem"}, resp_elem_id, v.elem);
    chk({nm, ".addr"}, resp_addr, v.addr[15:0]);
    chk({nm, ".len"}, resp_len, v.len);
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    clear_stats();
    send_frame(v, 0);
    repeat (4) @(negedge clk);
    if (v.exp_err != 3'd0) exp_drop = sat(exp_drop);
    if (v.exp_resp)        exp_pkt  = sat(exp_pkt);
    chk_writes(nm, v, v.exp_wr);
    chk({nm, ".err_pulses"}, n_errp, (v.exp_err != 3'd0) ? 1 : 0);
    if (v.exp_err != 3'd0) chk({nm, ".err_code"}, err_code, v.exp_err);
    chk({nm, ".n_resp"}, n_resp, v.exp_resp ? 1 : 0);
    if (v.exp_resp) chk_resp(nm, v);
    chk({nm, ".pkt_cnt"}, pkt_cnt, exp_pkt);
    chk({nm, ".drop_cnt"}, drop_cnt, exp_drop);
  endtask

  vec_t tv[12];
  vec_t rd, wr2, bb, rv;

  initial begin
    //        b0     msg    typ    id     elem      addr          len    adj nd  d4            err  wr resp
    tv[0]  = '{8'h10, 8'h04, 8'h10, 8'h5A, 16'h0003, 48'h0100,     16'd4,   0, 4, 32'hDEADBEEF, 3'd0, 4, 1};
    tv[1]  = '{8'h10, 8'h02, 8'h10, 8'h77, 16'h0001, 48'h0100,     16'd4,   0, 4, 32'h0,        3'd2, 0, 0};
    tv[2]  = '{8'h10, 8'h04, 8'h10, 8'h11, 16'h1234, 48'hFFFC,     16'd4,   0, 6, 32'h01020304, 3'd0, 4, 1};
    tv[3]  = '{8'h10, 8'h04, 8'h10, 8'h22, 16'h0000, 48'h0200,     16'd300, 0, 4, 32'h0,        3'd4, 0, 0};
    tv[4]  = '{8'h10, 8'h04, 8'h10, 8'h33, 16'h0000, 48'h1_0000,   16'd4,   0, 4, 32'h0,        3'd5, 0, 0};
    tv[5]  = '{8'h10, 8'h04, 8'h10, 8'h34, 16'h0000, 48'hFF01,     16'd256, 0, 4, 32'h0,        3'd5, 0, 0};
    tv[6]  = '{8'h11, 8'h04, 8'h10, 8'h35, 16'h0000, 48'h0100,     16'd4,   0, 4, 32'h0,        3'd1, 0, 0};
    tv[7]  = '{8'h10, 8'h04, 8'h10, 8'h36, 16'h0000, 48'h0100,     16'd4,   1, 4, 32'h0,        3'd6, 0, 0};
    tv[8]  = '{8'h10, 8'h04, 8'h20, 8'h37, 16'h0000, 48'h0100,     16'd4,   0, 4, 32'h0,        3'd3, 0, 0};
    tv[9]  = '{8'h10, 8'h04, 8'h10, 8'h44, 16'h0000, 48'h0300,     16'd8,   0, 3, 32'hA1B2C3D4, 3'd7, 3, 0};
    tv[10] = '{8'h10, 8'h04, 8'h00, 8'h55, 16'h0BEE, 48'h0020,     16'd16,  0, 5, 32'h0,        3'd0, 0, 1};
    tv[11] = '{8'h10, 8'h04, 8'h00, 8'h66, 16'h0000, 48'h0020,     16'd0,   0, 0, 32'h0,        3'd4, 0, 0};
    rd     = '{8'h10, 8'h04, 8'h00, 8'h99, 16'h0042, 48'h0020,     16'd16,  0, 0, 32'h0,        3'd0, 0, 1};
    wr2    = '{8'h10, 8'h04, 8'h10, 8'h9A, 16'h0043, 48'h0400,     16'd2,   0, 2, 32'hCAFE0000, 3'd0, 2, 1};
    bb     = '{8'h10, 8'h04, 8'h10, 8'hB0, 16'h0007, 48'h0010,     16'd1,   0, 1, 32'h5A000000, 3'd0, 1, 1};
    rv     = '{8'h10, 8'h04, 8'h10, 8'hC0, 16'h0009, 48'h0500,     16'd8,   0, 8, 32'h11223344, 3'd0, 8, 1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.s_ready", s_ready, 1'b1);
    chk("rst.outs", {mem_we, resp_valid, err_pulse, err_code, mem_addr, mem_data}, '0);
    chk("rst.cnts", {pkt_cnt, drop_cnt}, '0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), tv[i]);

    // Read with resp_ready held low; the next frame arrives during RESP and must stall.
    clear_stats();
    resp_ready = 1'b0;
    send_frame(rd, 0);
    fork
      send_frame(wr2, 0);
      begin
        for (int i = 0; i < 5; i++) begin
          chk($sformatf("stall%0d.rv_nrdy", i), {resp_valid, s_ready}, 2'b10);
          if (i < 4) @(negedge clk);
        end
        chk_resp("stall.rd", rd);
        exp_pkt = sat(exp_pkt);
        resp_ready = 1'b1;
        @(negedge clk);
        chk("stall.pkt_after_release", pkt_cnt, exp_pkt);
      end
    join
    repeat (4) @(negedge clk);
    exp_pkt = sat(exp_pkt);
    chk("stall.n_resp", n_resp, 2);
    chk("stall.rv_cycles", n_rvc, 6);
    chk("stall.unstable", n_unstable, 0);
    chk_writes("stall.wr2", wr2, 2);
    chk_resp("stall.wr2", wr2);
    chk("stall.pkt_cnt", pkt_cnt, exp_pkt);

    // Back-to-back frames drive pkt_cnt into saturation.
    clear_stats();
    for (int i = 0; i < 3; i++) send_frame(bb, 0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) exp_pkt = sat(exp_pkt);
    chk("b2b.n_resp", n_resp, 3);
    chk("b2b.n_wr", wq_addr.size(), 3);
    chk("b2b.pkt_cnt_sat", pkt_cnt, exp_pkt);
    chk("b2b.drop_cnt", drop_cnt, exp_drop);

    // Reset in the middle of write payload.
    send_frame(rv, 42 + 16 + 4);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst.s_ready", s_ready, 1'b1);
    chk("midrst.outs", {mem_we, resp_valid, err_pulse, err_code, resp_len, resp_addr}, '0);
    chk("midrst.cnts", {pkt_cnt, drop_cnt}, '0);
    reset = 1'b0;
    exp_pkt = 0; exp_drop = 0;
    @(negedge clk);
    run_vec("post_rst", rv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
